ring_switch_alloc: RTL and testbench

RING_SWITCH_ALLOC -- requirements
Module: ring_switch_alloc

---
 rtl/ring_noc_pkg.sv | 38 +++
 rtl/ring_switch_alloc_if.sv | 28 ++
 rtl/ring_switch_alloc_rr_arb3.sv | 54 +++++
 rtl/ring_switch_alloc.sv | 123 ++++++++++++
 tb/tb_ring_switch_alloc.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ring_noc_pkg.sv
// Shared encodings for the ring switch: target-port codes, crossbar select
// one-hots, round-robin pointer states and the default credit depth.
package ring_noc_pkg;

  localparam int CREDIT_DEPTH_DEF = 8;
  localparam int NPORT            = 3;

  typedef enum logic [1:0] {
    PORT_L   = 2'b00,
    PORT_E   = 2'b01,
    PORT_W   = 2'b10,
    PORT_INV = 2'b11
  } port_e;

  typedef enum logic [1:0] {
    PTR_L = 2'b00,
    PTR_E = 2'b01,
    PTR_W = 2'b10
  } rr_ptr_e;

  localparam logic [4:0] SEL_IDLE = 5'b00000;
  localparam logic [4:0] SEL_L    = 5'b00001;
  localparam logic [4:0] SEL_E    = 5'b00010;
  localparam logic [4:0] SEL_W    = 5'b00100;

  // Output one-hot (bit0 = L, bit1 = E, bit2 = W) addressed by a port code.
  function automatic logic [2:0] port_onehot(input logic [1:0] p);
    logic [2:0] oh;
    case (p)
      PORT_L:  oh = 3'b001;
      PORT_E:  oh = 3'b010;
      PORT_W:  oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/ring_switch_alloc_if.sv
// Request/grant/credit bundle between the ring switch allocator and its
// requesters and downstream credit sources.
interface ring_switch_alloc_if #(
  parameter int CW = 4
);
  logic [2:0]    req_valid;
  logic [5:0]    req_port;
  logic [2:0]    credit_ret;
  logic [2:0]    gnt;
  logic [4:0]    sel_l;
  logic [4:0]    sel_e;
  logic [4:0]    sel_w;
  logic [2:0]    out_valid;
  logic [CW-1:0] credit_l;
  logic [CW-1:0] credit_e;
  logic [CW-1:0] credit_w;
  logic          err;

  modport master (
    output req_valid, req_port, credit_ret,
    input  gnt, sel_l, sel_e, sel_w, out_valid, credit_l, credit_e, credit_w, err
  );

  modport slave (
    input  req_valid, req_port, credit_ret,
    output gnt, sel_l, sel_e, sel_w, out_valid, credit_l, credit_e, credit_w, err
  );
endinterface

// File: rtl/ring_switch_alloc_rr_arb3.sv
// Three-requester round-robin arbiter; after a grant the requester just past
// the winner gets highest priority.
module rr_arb3
  import ring_noc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req_i,
  output logic [2:0] gnt_o
);

  rr_ptr_e ptr_q;
  rr_ptr_e ptr_d;

  // Pointer register; local input has top priority out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= PTR_L;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Scan from the pointer and move it just past the winner.
  always_comb begin
    gnt_o = 3'b000;
    ptr_d = ptr_q;
    case (ptr_q)
      PTR_L: begin
        if (req_i[0])      begin gnt_o = 3'b001; ptr_d = PTR_E; end
        else if (req_i[1]) begin gnt_o = 3'b010; ptr_d = PTR_W; end
        else if (req_i[2]) begin gnt_o = 3'b100; ptr_d = PTR_L; end
        else               begin gnt_o = 3'b000; ptr_d = ptr_q; end
      end
      PTR_E: begin
        if (req_i[1])      begin gnt_o = 3'b010; ptr_d = PTR_W; end
        else if (req_i[2]) begin gnt_o = 3'b100; ptr_d = PTR_L; end
        else if (req_i[0]) begin gnt_o = 3'b001; ptr_d = PTR_E; end
        else               begin gnt_o = 3'b000; ptr_d = ptr_q; end
      end
      PTR_W: begin
        if (req_i[2])      begin gnt_o = 3'b100; ptr_d = PTR_L; end
        else if (req_i[0]) begin gnt_o = 3'b001; ptr_d = PTR_E; end
        else if (req_i[1]) begin gnt_o = 3'b010; ptr_d = PTR_W; end
        else               begin gnt_o = 3'b000; ptr_d = ptr_q; end
      end
      default: begin
        gnt_o = 3'b000;
        ptr_d = PTR_L;
      end
    endcase
  end

endmodule

// File: rtl/ring_switch_alloc.sv
// Ring-node switch allocator: credit-gated eligibility, one round-robin
// arbiter per output, registered grants/selects and per-output credit counts.
module ring_switch_alloc
  import ring_noc_pkg::*;
#(
  parameter int CREDIT_DEPTH = CREDIT_DEPTH_DEF,
  parameter int CW           = 4
) (
  input logic               clk,
  input logic               rst,
  ring_switch_alloc_if.slave bus
);

  localparam logic [CW-1:0] CRED_FULL = CW'(CREDIT_DEPTH);
  localparam logic [CW-1:0] CRED_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CRED_ZERO = {CW{1'b0}};

  logic [2:0]    elig_s     [3];
  logic [2:0]    arb_gnt_s  [3];
  logic [2:0]    tgt_s;
  logic [2:0]    invalid_s;
  logic [2:0]    overflow_s;

  logic [CW-1:0] credit_q   [3];
  logic [CW-1:0] credit_d   [3];
  logic [4:0]    sel_q      [3];
  logic [4:0]    sel_d      [3];
  logic [2:0]    gnt_q,  gnt_d;
  logic [2:0]    ov_q,   ov_d;
  logic          err_q,  err_d;

  // Eligibility per output (index o) for each input (bit i); a port code of 11 is flagged.
  always_comb begin
    tgt_s     = 3'b000;
    invalid_s = 3'b000;
    for (int o = 0; o < 3; o++) begin
      elig_s[o] = 3'b000;
    end
    for (int i = 0; i < 3; i++) begin
      tgt_s        = port_onehot(bus.req_port[2*i +: 2]);
      invalid_s[i] = bus.req_valid[i] & (bus.req_port[2*i +: 2] == PORT_INV);
      for (int o = 0; o < 3; o++) begin
        elig_s[o][i] = bus.req_valid[i] & tgt_s[o] & (credit_q[o] != CRED_ZERO);
      end
    end
  end

  for (genvar o = 0; o < 3; o++) begin : g_arb
    rr_arb3 u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_i (elig_s[o]),
      .gnt_o (arb_gnt_s[o])
    );
  end

  // Credit update: a grant and a return in the same cycle cancel; returns saturate at full.
  always_comb begin
    for (int o = 0; o < 3; o++) begin
      credit_d[o]   = credit_q[o];
      overflow_s[o] = 1'b0;
      if ((|arb_gnt_s[o]) && !bus.credit_ret[o]) begin
        credit_d[o] = credit_q[o] - CRED_ONE;
      end else if (!(|arb_gnt_s[o]) && bus.credit_ret[o]) begin
        if (credit_q[o] == CRED_FULL) begin
          overflow_s[o] = 1'b1;
        end else begin
          credit_d[o] = credit_q[o] + CRED_ONE;
        end
      end else begin
        credit_d[o] = credit_q[o];
      end
    end
  end

  // Next values of the registered grant, select, valid and error outputs.
  always_comb begin
    gnt_d = arb_gnt_s[0] | arb_gnt_s[1] | arb_gnt_s[2];
    err_d = (|invalid_s) | (|overflow_s);
    ov_d  = 3'b000;
    for (int o = 0; o < 3; o++) begin
      ov_d[o] = |arb_gnt_s[o];
      case (arb_gnt_s[o])
        3'b001:  sel_d[o] = SEL_L;
        3'b010:  sel_d[o] = SEL_E;
        3'b100:  sel_d[o] = SEL_W;
        default: sel_d[o] = SEL_IDLE;
      endcase
    end
  end

  // Output and credit registers; reset clears traffic and refills credits at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q <= 3'b000;
      ov_q  <= 3'b000;
      err_q <= 1'b0;
      for (int o = 0; o < 3; o++) begin
        sel_q[o]    <= SEL_IDLE;
        credit_q[o] <= CRED_FULL;
      end
    end else begin
      gnt_q <= gnt_d;
      ov_q  <= ov_d;
      err_q <= err_d;
      for (int o = 0; o < 3; o++) begin
        sel_q[o]    <= sel_d[o];
        credit_q[o] <= credit_d[o];
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.out_valid = ov_q;
  assign bus.err       = err_q;
  assign bus.sel_l     = sel_q[0];
  assign bus.sel_e     = sel_q[1];
  assign bus.sel_w     = sel_q[2];
  assign bus.credit_l  = credit_q[0];
  assign bus.credit_e  = credit_q[1];
  assign bus.credit_w  = credit_q[2];

endmodule

// File: tb/tb_ring_switch_alloc.sv
// Self-checking bench for ring_switch_alloc: directed vector table, corner
// sequences (credit drain, same-cycle return, async reset) and random traffic.
module tb_ring_switch_alloc;

  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  ring_switch_alloc_if #(.CW(CW)) bus ();

  ring_switch_alloc #(.CREDIT_DEPTH(DEPTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [2:0] rv;
    logic [5:0] rp;
    logic [2:0] cr;
    logic [2:0] gnt;
    logic [4:0] sl;
    logic [4:0] se;
    logic [4:0] sw;
    logic [2:0] ov;
    int         cl;
    int         ce;
    int         cw;
    logic       err;
  } vec_t;

  vec_t vecs [11];

  logic [2:0] exp_gnt;
  logic [2:0] exp_ov;
  logic [4:0] exp_sel [3];
  int         exp_cred[3];
  logic       exp_err;

  int m_cred[3];
  int m_ptr [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".gnt"},      32'(bus.gnt),       32'(exp_gnt));
    chk({tag, ".sel_l"},    32'(bus.sel_l),     32'(exp_sel[0]));
    chk({tag, ".sel_e"},    32'(bus.sel_e),     32'(exp_sel[1]));
    chk({tag, ".sel_w"},    32'(bus.sel_w),     32'(exp_sel[2]));
    chk({tag, ".out_valid"},32'(bus.out_valid), 32'(exp_ov));
    chk({tag, ".credit_l"}, 32'(bus.credit_l),  32'(exp_cred[0]));
    chk({tag, ".credit_e"}, 32'(bus.credit_e),  32'(exp_cred[1]));
    chk({tag, ".credit_w"}, 32'(bus.credit_w),  32'(exp_cred[2]));
    chk({tag, ".err"},      32'(bus.err),       32'(exp_err));
  endtask

  task automatic drive(input logic [2:0] rv, input logic [5:0] rp, input logic [2:0] cr);
    bus.req_valid  = rv;
    bus.req_port   = rp;
    bus.credit_ret = cr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_gnt = 3'b000;
    exp_ov  = 3'b000;
    exp_err = 1'b0;
    for (int o = 0; o < 3; o++) begin
      m_cred[o]   = DEPTH;
      m_ptr[o]    = 0;
      exp_sel[o]  = 5'b00000;
      exp_cred[o] = DEPTH;
    end
  endtask

  task automatic do_reset();
    drive(3'b000, 6'b000000, 3'b000);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_all("reset");
    rst = 1'b1;
  endtask

  // Reference: for each output, scan inputs from its pointer (mod 3) for the
  // first one aiming at it while credits remain; then settle credits and err.
  task automatic model_step();
    int win;
    int i;
    exp_gnt = 3'b000;
    exp_ov  = 3'b000;
    exp_err = 1'b0;
    for (int o = 0; o < 3; o++) begin
      win = -1;
      for (int k = 0; k < 3; k++) begin
        i = (m_ptr[o] + k) % 3;
        if (win < 0 && bus.req_valid[i] && int'(bus.req_port[2*i +: 2]) == o && m_cred[o] > 0)
          win = i;
      end
      exp_sel[o] = 5'b00000;
      if (win >= 0) begin
        exp_gnt[win] = 1'b1;
        exp_ov[o]    = 1'b1;
        exp_sel[o]   = 5'(1 << win);
        m_ptr[o]     = (win + 1) % 3;
      end
      if (win >= 0 && !bus.credit_ret[o]) begin
        m_cred[o] = m_cred[o] - 1;
      end else if (win < 0 && bus.credit_ret[o]) begin
        if (m_cred[o] == DEPTH) exp_err = 1'b1;
        else m_cred[o] = m_cred[o] + 1;
      end
      exp_cred[o] = m_cred[o];
    end
    for (int n = 0; n < 3; n++) begin
      if (bus.req_valid[n] && bus.req_port[2*n +: 2] == 2'b11) exp_err = 1'b1;
    end
  endtask

  initial begin
    logic       pend [3];
    logic [1:0] ports[3];
    logic [2:0] rv;
    logic [5:0] rp;
    logic [2:0] cr;
    int         thr;

    rst = 1'b0;
    drive(3'b000, 6'b000000, 3'b000);

    // rv, rp, cr | gnt, sel_l, sel_e, sel_w, out_valid, credit l/e/w, err
    vecs[0]  = '{3'b111, 6'b010101, 3'b000, 3'b001, 5'b00000, 5'b00001, 5'b00000, 3'b010, 8, 7, 8, 1'b0};
    vecs[1]  = '{3'b111, 6'b010101, 3'b000, 3'b010, 5'b00000, 5'b00010, 5'b00000, 3'b010, 8, 6, 8, 1'b0};
    vecs[2]  = '{3'b111, 6'b010101, 3'b000, 3'b100, 5'b00000, 5'b00100, 5'b00000, 3'b010, 8, 5, 8, 1'b0};
    vecs[3]  = '{3'b111, 6'b010101, 3'b000, 3'b001, 5'b00000, 5'b00001, 5'b00000, 3'b010, 8, 4, 8, 1'b0};
    vecs[4]  = '{3'b111, 6'b010010, 3'b000, 3'b111, 5'b00010, 5'b00100, 5'b00001, 3'b111, 7, 3, 7, 1'b0};
    vecs[5]  = '{3'b000, 6'b000000, 3'b111, 3'b000, 5'b00000, 5'b00000, 5'b00000, 3'b000, 8, 4, 8, 1'b0};
    vecs[6]  = '{3'b000, 6'b000000, 3'b001, 3'b000, 5'b00000, 5'b00000, 5'b00000, 3'b000, 8, 4, 8, 1'b1};
    vecs[7]  = '{3'b000, 6'b000000, 3'b000, 3'b000, 5'b00000, 5'b00000, 5'b00000, 3'b000, 8, 4, 8, 1'b0};
    vecs[8]  = '{3'b001, 6'b000011, 3'b000, 3'b000, 5'b00000, 5'b00000, 5'b00000, 3'b000, 8, 4, 8, 1'b1};
    vecs[9]  = '{3'b001, 6'b000011, 3'b000, 3'b000, 5'b00000, 5'b00000, 5'b00000, 3'b000, 8, 4, 8, 1'b1};
    vecs[10] = '{3'b000, 6'b000000, 3'b000, 3'b000, 5'b00000, 5'b00000, 5'b00000, 3'b000, 8, 4, 8, 1'b0};

    do_reset();
    for (int n = 0; n < 11; n++) begin
      drive(vecs[n].rv, vecs[n].rp, vecs[n].cr);
      step();
      exp_gnt     = vecs[n].gnt;
      exp_sel[0]  = vecs[n].sl;
      exp_sel[1]  = vecs[n].se;
      exp_sel[2]  = vecs[n].sw;
      exp_ov      = vecs[n].ov;
      exp_cred[0] = vecs[n].cl;
      exp_cred[1] = vecs[n].ce;
      exp_cred[2] = vecs[n].cw;
      exp_err     = vecs[n].err;
      compare_all($sformatf("vec%0d", n));
    end

    // Drain east credits with a single persistent requester, then return one.
    do_reset();
    drive(3'b001, 6'b000001, 3'b000);
    for (int n = 1; n <= 9; n++) begin
      step();
      chk($sformatf("drain%0d.gnt", n),      32'(bus.gnt),      (n <= 8) ? 32'd1 : 32'd0);
      chk($sformatf("drain%0d.credit_e", n), 32'(bus.credit_e), (n <= 8) ? 32'(8 - n) : 32'd0);
    end
    drive(3'b001, 6'b000001, 3'b010);
    step();
    chk("ret.gnt",      32'(bus.gnt),      32'd0);
    chk("ret.credit_e", 32'(bus.credit_e), 32'd1);
    drive(3'b001, 6'b000001, 3'b000);
    step();
    chk("regrant.gnt",      32'(bus.gnt),      32'd1);
    chk("regrant.sel_e",    32'(bus.sel_e),    32'd1);
    chk("regrant.credit_e", 32'(bus.credit_e), 32'd0);
    step();
    chk("stall.gnt",      32'(bus.gnt),      32'd0);
    chk("stall.credit_e", 32'(bus.credit_e), 32'd0);

    // Grant and return on the same output cancel; overflow return on local.
    do_reset();
    drive(3'b001, 6'b000001, 3'b000);
    repeat (3) step();
    chk("pre.credit_e", 32'(bus.credit_e), 32'd5);
    drive(3'b001, 6'b000001, 3'b010);
    step();
    chk("same.gnt",      32'(bus.gnt),      32'd1);
    chk("same.credit_e", 32'(bus.credit_e), 32'd5);
    drive(3'b000, 6'b000000, 3'b001);
    step();
    chk("ovf.credit_l", 32'(bus.credit_l), 32'd8);
    chk("ovf.err",      32'(bus.err),      32'd1);
    drive(3'b000, 6'b000000, 3'b000);
    step();
    chk("ovf_end.err",  32'(bus.err),      32'd0);

    // Reset asserted between edges during traffic; arbitration restarts at local.
    do_reset();
    drive(3'b111, 6'b010101, 3'b000);
    step();
    step();
    chk("mid.gnt", 32'(bus.gnt), 32'd2);
    #3;
    rst = 1'b0;
    #1;
    chk("async.gnt",       32'(bus.gnt),       32'd0);
    chk("async.sel_e",     32'(bus.sel_e),     32'd0);
    chk("async.out_valid", 32'(bus.out_valid), 32'd0);
    chk("async.credit_e",  32'(bus.credit_e),  32'd8);
    step();
    chk("held.gnt",        32'(bus.gnt),       32'd0);
    chk("held.credit_e",   32'(bus.credit_e),  32'd8);
    rst = 1'b1;
    step();
    chk("restart.gnt",      32'(bus.gnt),      32'd1);
    chk("restart.sel_e",    32'(bus.sel_e),    32'd1);
    chk("restart.credit_e", 32'(bus.credit_e), 32'd7);

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pend[i]  = 1'b0;
      ports[i] = 2'b00;
    end
    for (int c = 0; c < 400; c++) begin
      thr = (c < 200) ? 3 : 1;
      for (int i = 0; i < 3; i++) begin
        if (pend[i] && ports[i] == 2'b11) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 9) < 6) begin
          pend[i]  = 1'b1;
          ports[i] = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        end
        rv[i]         = pend[i];
        rp[2*i +: 2]  = ports[i];
        cr[i]         = ($urandom_range(0, 9) < thr) ? 1'b1 : 1'b0;
      end
      drive(rv, rp, cr);
      model_step();
      step();
      compare_all($sformatf("rand%0d", c));
      for (int i = 0; i < 3; i++) begin
        if (exp_gnt[i]) pend[i] = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
